// File: rtl/spi_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_share_arbiter
// Purpose  : Round-robin scheduler that shares one single-lane SPI serializer
//            (trigger/ready handshake) between NREQ requesters. The winner's
//            word and bit count are latched, one trigger is fired, and the
//            serializer's ready line is tracked until the transfer completes.
// Ports    : iClk/iRst          clock, synchronous active-high reset
//            iReq/iReqData/iReqWidth  per-requester level request, word, width
//            oGrant/oDone       one-hot acceptance / completion pulses
//            oSel               index of current or last owner (CS mux)
//            oSpiTrig/oSpiData/oSpiWidth/iSpiReady  serializer handshake
//            oBusy              high whenever not IDLE
//            oTimeout           abort pulse (watchdog build only)
// Options  : define SPI_SHARE_ARB_TIMEOUT_EN to build the START/RUN watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module spi_share_arbiter #(
   parameter int NREQ     = 4,
   parameter int MAXWIDTH = 128,
   parameter int GAP      = 2,
   parameter int TIMEOUT  = 1023
) (
   input  logic                       iClk,
   input  logic                       iRst,
   input  logic [NREQ-1:0]            iReq,
   input  logic [NREQ*MAXWIDTH-1:0]   iReqData,
   input  logic [NREQ*8-1:0]          iReqWidth,
   output logic [NREQ-1:0]            oGrant,
   output logic [NREQ-1:0]            oDone,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] oSel,
   output logic                       oSpiTrig,
   output logic [MAXWIDTH-1:0]        oSpiData,
   output logic [7:0]                 oSpiWidth,
   input  logic                       iSpiReady,
   output logic                       oBusy,
   output logic                       oTimeout
);

   localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   localparam logic [3:0] GAP_LD = 4'(GAP);
   localparam logic [7:0] WMAX   = (MAXWIDTH > 255) ? 8'd255 : 8'(MAXWIDTH);
   // State to enter after a transfer ends; GAP=0 skips the GAP state.
   localparam logic [1:0] S_AFTER = (GAP == 0) ? S_IDLE : S_GAP;

   // Elaboration-time parameter range checks.
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("spi_share_arbiter: NREQ must be 2..8");
   end
   if (GAP < 0 || GAP > 15) begin : g_bad_gap
      $error("spi_share_arbiter: GAP must be 0..15");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("spi_share_arbiter: TIMEOUT must be >= 1");
   end

   logic [1:0]          state, state_next;
   logic [SELW-1:0]     rr_ptr, winner, sel_r;
   logic                found, zero_w, arb_fire, xfer_done, xfer_abort, to_hit;
   logic [3:0]          gap_cnt;
   logic [7:0]          win_width;
   logic [NREQ-1:0]     win_onehot, sel_onehot;
   logic [NREQ-1:0]     grant_r, done_r, grant_nxt, done_nxt;
   logic                trig_r, trig_nxt;
   logic [MAXWIDTH-1:0] data_r;
   logic [7:0]          width_r;
   logic [SELW:0]       scan;

   logic [MAXWIDTH-1:0] req_data  [NREQ];
   logic [7:0]          req_width [NREQ];

   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign req_data[k]  = iReqData[k*MAXWIDTH +: MAXWIDTH];
      assign req_width[k] = iReqWidth[k*8 +: 8];
   end

   // Upward search with wrap starting at the round-robin pointer.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      scan   = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan = {1'b0, rr_ptr} + (SELW+1)'(i);
         if (scan >= (SELW+1)'(NREQ))
            scan = scan - (SELW+1)'(NREQ);
         if (!found && iReq[scan[SELW-1:0]]) begin
            found  = 1'b1;
            winner = scan[SELW-1:0];
         end
      end
   end

   assign zero_w    = (req_width[winner] == 8'd0);
   assign win_width = (req_width[winner] > WMAX) ? WMAX : req_width[winner];

   // State register (plus registered outputs and bookkeeping).
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state   <= S_IDLE;
         rr_ptr  <= '0;
         gap_cnt <= '0;
         grant_r <= '0;
         done_r  <= '0;
         trig_r  <= 1'b0;
         sel_r   <= '0;
         data_r  <= '0;
         width_r <= '0;
      end else begin
         state   <= state_next;
         grant_r <= grant_nxt;
         done_r  <= done_nxt;
         trig_r  <= trig_nxt;
         if (arb_fire) begin
            sel_r   <= winner;
            data_r  <= req_data[winner];
            width_r <= win_width;
            rr_ptr  <= (winner == SELW'(NREQ-1)) ? '0 : winner + 1'b1;
         end
         // Load on entry to GAP, count down while in it.
         if (state_next == S_GAP && state != S_GAP)
            gap_cnt <= GAP_LD;
         else if (state == S_GAP)
            gap_cnt <= gap_cnt - 4'd1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      arb_fire   = 1'b0;
      xfer_done  = 1'b0;
      xfer_abort = 1'b0;
      case (state)
         S_IDLE: begin
            // A serializer still shifting (e.g. after reset) blocks arbitration.
            if (iSpiReady && found) begin
               arb_fire   = 1'b1;
               state_next = zero_w ? S_AFTER : S_START;
            end
         end
         S_START: begin
            if (to_hit) begin
               xfer_abort = 1'b1;
               state_next = S_AFTER;
            end else if (!iSpiReady) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (iSpiReady) begin
               xfer_done  = 1'b1;
               state_next = S_AFTER;
            end else if (to_hit) begin
               xfer_abort = 1'b1;
               state_next = S_AFTER;
            end
         end
         S_GAP: begin
            if (gap_cnt <= 4'd1)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output logic: next values of the pulse outputs and the direct drives.
   always_comb begin
      win_onehot         = '0;
      win_onehot[winner] = 1'b1;
      sel_onehot         = '0;
      sel_onehot[sel_r]  = 1'b1;
      grant_nxt          = arb_fire ? win_onehot : '0;
      trig_nxt           = arb_fire && !zero_w;
      // A zero-width grant completes immediately with no trigger.
      if (arb_fire && zero_w)
         done_nxt = win_onehot;
      else if (xfer_done)
         done_nxt = sel_onehot;
      else
         done_nxt = '0;
   end

   assign oGrant    = grant_r;
   assign oDone     = done_r;
   assign oSel      = sel_r;
   assign oSpiTrig  = trig_r;
   assign oSpiData  = data_r;
   assign oSpiWidth = width_r;
   assign oBusy     = (state != S_IDLE);

`ifdef SPI_SHARE_ARB_TIMEOUT_EN
   localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TOW-1:0] to_cnt;
   logic           timeout_r;

   // Cleared when a transfer is granted (entry to START), counts in START/RUN.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         to_cnt    <= '0;
         timeout_r <= 1'b0;
      end else begin
         timeout_r <= xfer_abort;
         if (arb_fire)
            to_cnt <= '0;
         else if (state == S_START || state == S_RUN)
            to_cnt <= to_cnt + 1'b1;
      end
   end

   assign to_hit   = (state == S_START || state == S_RUN) &&
                     (to_cnt == TOW'(TIMEOUT - 1));
   assign oTimeout = timeout_r;
`else
   assign to_hit   = 1'b0;
   assign oTimeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_share_arbiter
// Purpose  : Directed self-checking bench for spi_share_arbiter with a
//            behavioural serializer (ready drops after a trigger, returns
//            after ser_len cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_share_arbiter;

   localparam int NREQ = 4;
   localparam int MW   = 128;
   localparam int GAP  = 2;
   localparam int TO   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*MW-1:0] rdata;
   logic [NREQ*8-1:0] rwidth;
   logic [NREQ-1:0]   grant, done;
   logic [1:0]        sel;
   logic              trig;
   logic [MW-1:0]     sdata;
   logic [7:0]        swidth;
   logic              ready;
   logic              busy, tmo;

   int errors = 0;
   int checks = 0;

   int ser_len   = 5;
   int ser_cnt   = 0;
   bit ser_force = 0;

   spi_share_arbiter #(
      .NREQ(NREQ), .MAXWIDTH(MW), .GAP(GAP), .TIMEOUT(TO)
   ) dut (
      .iClk(clk), .iRst(rst), .iReq(req), .iReqData(rdata), .iReqWidth(rwidth),
      .oGrant(grant), .oDone(done), .oSel(sel), .oSpiTrig(trig),
      .oSpiData(sdata), .oSpiWidth(swidth), .iSpiReady(ready),
      .oBusy(busy), .oTimeout(tmo)
   );

   always #5 clk = ~clk;

   // Serializer model, updated on the falling edge.
   initial begin
      ready = 1'b1;
      forever begin
         @(negedge clk);
         if (ser_force) begin
            ready = 1'b1; ser_cnt = 0; ser_force = 0;
         end else if (trig) begin
            ready = 1'b0; ser_cnt = ser_len;
         end else if (!ready && ser_cnt > 0) begin
            ser_cnt = ser_cnt - 1;
            if (ser_cnt == 0) ready = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      req = '0; rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy !== 1'b0 || ready !== 1'b1) && n < 300) begin tick(); n++; end
      checks++;
      if (n >= 300) begin errors++; $display("FAIL %s_idle: busy=%b ready=%b after %0d cycles, want idle", tag, busy, ready, n); end
   endtask

   task automatic test_reset();
      req = '0; rst = 1'b1; tick(); tick();
      checks++; if (grant !== 4'b0)   begin errors++; $display("FAIL rst_grant: got %b want 0", grant); end
      checks++; if (done !== 4'b0)    begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (sel !== 2'd0)     begin errors++; $display("FAIL rst_sel: got %0d want 0", sel); end
      checks++; if (trig !== 1'b0)    begin errors++; $display("FAIL rst_trig: got %b want 0", trig); end
      checks++; if (sdata !== '0)     begin errors++; $display("FAIL rst_data: got %h want 0", sdata); end
      checks++; if (swidth !== 8'd0)  begin errors++; $display("FAIL rst_width: got %0d want 0", swidth); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (tmo !== 1'b0)     begin errors++; $display("FAIL rst_timeout: got %b want 0", tmo); end
      rst = 1'b0; tick();
   endtask

   task automatic test_single();
      int n = 0;
      int extra = 0;
      rdata[0*MW +: MW] = {8'hA5, 120'h0};
      rwidth[0*8 +: 8]  = 8'd8;
      ser_len = 9;
      req = 4'b0001; tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
      checks++; if (trig !== 1'b1)     begin errors++; $display("FAIL single_trig: got %b want 1", trig); end
      checks++; if (swidth !== 8'd8)   begin errors++; $display("FAIL single_width: got %0d want 8", swidth); end
      checks++; if (sdata !== {8'hA5, 120'h0}) begin errors++; $display("FAIL single_data: got %h want a5<<120", sdata); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL single_busy_start: got %b want 1", busy); end
      req = 4'b0000;
      while (done === 4'b0 && n < 60) begin tick(); n++; if (trig) extra++; end
      checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", done); end
      checks++; if (n != 10)          begin errors++; $display("FAIL single_done_latency: got %0d want 10", n); end
      checks++; if (extra != 0)       begin errors++; $display("FAIL single_retrig: got %0d want 0", extra); end
      checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy_done: got %b want 1", busy); end
      tick();
      checks++; if (busy !== 1'b1 || done !== 4'b0) begin errors++; $display("FAIL single_gap1: busy=%b done=%b want 1/0000", busy, done); end
      tick();
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL single_gap_end: got %b want 0", busy); end
      checks++; if (swidth !== 8'd8 || sel !== 2'd0) begin errors++; $display("FAIL single_hold: width=%0d sel=%0d want 8/0", swidth, sel); end
   endtask

   task automatic test_contention();
      int ng = 0, nd = 0, t = 0, outst = 0, overlap = 0, gap_bad = 0, last_d = -100;
      logic [3:0] exp_g;
      do_reset();
      ser_len = 5;
      for (int k = 0; k < NREQ; k++) begin
         rdata[k*MW +: MW] = MW'(k + 1) << 100;
         rwidth[k*8 +: 8]  = 8'd16;
      end
      req = 4'b1111;
      while (nd < 4 && t < 400) begin
         tick(); t++;
         if (trig) begin
            if (outst != 0) overlap++;
            outst++;
            if (nd > 0 && (t - last_d) <= GAP) gap_bad++;
         end
         if (done !== 4'b0) begin
            if (outst > 0) outst--;
            nd++; last_d = t;
         end
         if (grant !== 4'b0) begin
            exp_g = 4'(1 << ng);
            checks++;
            if (grant !== exp_g) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", ng, grant, exp_g); end
            req = req & ~grant;
            ng++;
         end
      end
      checks++; if (nd != 4 || ng != 4) begin errors++; $display("FAIL contention_count: grants=%0d dones=%0d want 4/4", ng, nd); end
      checks++; if (overlap != 0) begin errors++; $display("FAIL contention_overlap: got %0d want 0", overlap); end
      checks++; if (gap_bad != 0) begin errors++; $display("FAIL contention_gap: got %0d short gaps want 0", gap_bad); end
      wait_idle("contention");
   endtask

   task automatic test_fairness();
      int ng = 0, t = 0;
      int exp_idx [4] = '{0, 2, 0, 2};
      logic [3:0] exp_g;
      do_reset();
      ser_len = 3;
      req = 4'b0101;
      while (ng < 4 && t < 400) begin
         tick(); t++;
         if (grant !== 4'b0) begin
            exp_g = 4'(1 << exp_idx[ng]);
            checks++;
            if (grant !== exp_g) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", ng, grant, exp_g); end
            ng++;
         end
      end
      checks++; if (ng != 4) begin errors++; $display("FAIL fair_count: got %0d want 4", ng); end
      req = 4'b0000;
      wait_idle("fair");
   endtask

   task automatic test_width();
      int trigs = 0;
      do_reset();
      rwidth[1*8 +: 8] = 8'd0;
      req = 4'b0010; tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL w0_grant: got %b want 0010", grant); end
      checks++; if (done !== 4'b0010)  begin errors++; $display("FAIL w0_done: got %b want 0010", done); end
      checks++; if (trig !== 1'b0)     begin errors++; $display("FAIL w0_trig: got %b want 0", trig); end
      req = 4'b0000;
      for (int i = 0; i < 5; i++) begin if (trig) trigs++; tick(); end
      checks++; if (trigs != 0) begin errors++; $display("FAIL w0_notrig: got %0d want 0", trigs); end
      wait_idle("w0");
      rwidth[2*8 +: 8]  = 8'd200;
      rdata[2*MW +: MW] = {16'hBEEF, 112'h1};
      ser_len = 4;
      req = 4'b0100; tick();
      checks++; if (swidth !== 8'd128) begin errors++; $display("FAIL w200_clamp: got %0d want 128", swidth); end
      checks++; if (trig !== 1'b1 || grant !== 4'b0100) begin errors++; $display("FAIL w200_grant: trig=%b grant=%b want 1/0100", trig, grant); end
      req = 4'b0000;
      wait_idle("w200");
      checks++; if (swidth !== 8'd128 || sel !== 2'd2 || sdata !== {16'hBEEF, 112'h1}) begin errors++; $display("FAIL w200_hold: width=%0d sel=%0d data=%h", swidth, sel, sdata); end
   endtask

   task automatic test_reset_mid_run();
      int n = 0, pdone = 0, saw_low = 0;
      do_reset();
      ser_len = 20;
      rwidth[0*8 +: 8] = 8'd8;
      rwidth[1*8 +: 8] = 8'd12;
      req = 4'b0001; tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_grant0: got %b want 0001", grant); end
      req = 4'b0000;
      repeat (4) tick();
      rst = 1'b1; req = 4'b0010; tick();
      checks++; if (grant !== 4'b0 || done !== 4'b0 || trig !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL mid_rst_ctl: grant=%b done=%b trig=%b busy=%b want all 0", grant, done, trig, busy); end
      checks++; if (sel !== 2'd0 || sdata !== '0 || swidth !== 8'd0 || tmo !== 1'b0)
         begin errors++; $display("FAIL mid_rst_data: sel=%0d data=%h width=%0d tmo=%b want 0", sel, sdata, swidth, tmo); end
      tick();
      rst = 1'b0;
      while (grant === 4'b0 && n < 100) begin
         tick(); n++;
         if (done !== 4'b0) pdone++;
         if (ready === 1'b0 && grant === 4'b0) saw_low++;
      end
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b want 0010", grant); end
      checks++; if (ready !== 1'b1 || saw_low == 0) begin errors++; $display("FAIL mid_ready_guard: ready=%b low_cycles=%0d want 1/>0", ready, saw_low); end
      checks++; if (pdone != 0) begin errors++; $display("FAIL mid_partial_done: got %0d want 0", pdone); end
      req = 4'b0000;
      ser_len = 5;
      wait_idle("mid");
   endtask

`ifdef SPI_SHARE_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0, m = 0, nd = 0;
      do_reset();
      ser_len = 5000;
      req = 4'b0001; tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL to_grant0: got %b want 0001", grant); end
      req = 4'b0000;
      while (tmo === 1'b0 && n < 100) begin tick(); n++; if (done !== 4'b0) nd++; end
      checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", tmo); end
      checks++; if (n != 16)      begin errors++; $display("FAIL to_latency: got %0d want 16", n); end
      checks++; if (nd != 0 || done !== 4'b0) begin errors++; $display("FAIL to_nodone: got %0d dones want 0", nd); end
      ser_len = 5; ser_force = 1; req = 4'b0010;
      while (grant === 4'b0 && m < 50) begin tick(); m++; end
      checks++; if (grant !== 4'b0010 || m != 3) begin errors++; $display("FAIL to_next_grant: grant=%b after %0d want 0010 after 3", grant, m); end
      req = 4'b0000;
      wait_idle("to");
   endtask
`endif

   initial begin
      rst = 1'b0; req = '0; rdata = '0; rwidth = '0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_width();
      test_reset_mid_run();
`ifdef SPI_SHARE_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
